// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the multi-cycle core: sequencer states and
// decoder mux encodings.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    FAULT
  } state_t;

  localparam logic [1:0] GP_MUX_MEM = 2'b01;
  localparam logic [1:0] PC_SEQ     = 2'b00;
  localparam logic [1:0] PC_BR      = 2'b01;
  localparam logic [1:0] PC_JMP     = 2'b10;

  // Loads (memory data written back) and stores both need a data-memory access.
  function automatic logic is_mem_op(logic dm_we, logic gp_we, logic [1:0] gp_mux_sel);
    return dm_we | (gp_we & (gp_mux_sel == GP_MUX_MEM));
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive un-acked request cycles; flags the cycle in which the
// WAIT_MAX-th un-acked cycle occurs.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [W-1:0] LAST = W'(WAIT_MAX - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = count & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM: fetch handshake, IR, data-memory handshake, gated
// write/PC strobes, retired-instruction counter and memory-wait watchdog.
module mc_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  input  logic             dec_gp_we,
  input  logic             dec_dm_we,
  input  logic [1:0]       dec_gp_mux_sel,
  input  logic [1:0]       dec_pc_mux_sel,
  input  logic             branch_taken,
  output logic             dm_req,
  output logic             dm_we,
  input  logic             dm_ack,
  output logic             ld_capture,
  output logic             gp_we,
  output logic             pc_we,
  output logic [1:0]       pc_mux_sel,
  output logic [CNT_W-1:0] instret,
  output logic             fault
);

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [1:0]       pc_sel_q, pc_sel_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic waiting, acked, wd_clear, wd_count, wd_expired;

  assign waiting  = (state_q == FETCH) | (state_q == MEM);
  assign acked    = (state_q == FETCH) ? imem_ack : ((state_q == MEM) ? dm_ack : 1'b0);
  assign wd_clear = ~waiting | acked;
  assign wd_count = waiting & ~acked;

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      pc_sel_q  <= PC_SEQ;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_sel_q  <= pc_sel_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_sel_d  = pc_sel_q;
    instret_d = instret_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end else if (wd_expired) begin
          state_d = FAULT;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        // An untaken branch falls through to the sequential PC.
        if (dec_pc_mux_sel == PC_BR) begin
          pc_sel_d = branch_taken ? PC_BR : PC_SEQ;
        end else begin
          pc_sel_d = dec_pc_mux_sel;
        end
        state_d = is_mem_op(dec_dm_we, dec_gp_we, dec_gp_mux_sel) ? MEM : WB;
      end
      MEM: begin
        if (dm_ack) begin
          state_d = WB;
        end else if (wd_expired) begin
          state_d = FAULT;
        end
      end
      WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = FETCH;
      end
      FAULT: state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    ld_capture = 1'b0;
    gp_we      = 1'b0;
    pc_we      = 1'b0;
    pc_mux_sel = PC_SEQ;
    unique case (state_q)
      // Reset leaves the state at FETCH, so hold the request off until rst drops.
      FETCH: imem_req = ~rst;
      MEM: begin
        dm_req     = 1'b1;
        dm_we      = dec_dm_we;
        ld_capture = dm_ack & ~dec_dm_we;
      end
      WB: begin
        gp_we      = dec_gp_we;
        pc_we      = 1'b1;
        pc_mux_sel = pc_sel_q;
      end
      default: ;
    endcase
  end

  assign ir      = ir_q;
  assign instret = instret_q;
  assign fault   = (state_q == FAULT);

endmodule
